inst_fetch_buffer: RTL and testbench

//  Dual-issue instruction buffer between the IF stage and the ID stage. Queues up to two

---
 rtl/inst_fetch_buffer_pkg.sv | 31 +++
 rtl/inst_fetch_buffer_entry_ram.sv | 33 +++
 rtl/inst_fetch_buffer.sv | 151 +++++++++++++++
 tb/tb_inst_fetch_buffer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_buffer_pkg.sv
// Shared widths, entry field layout and helpers for the instruction fetch buffer.
package inst_fetch_buffer_pkg;

  localparam int EXCP_W           = 7;
  localparam int FB_INST_LSB      = 0;
  localparam int FB_PC_LSB        = 32;
  localparam int FB_EXCP_FLAG_LSB = 64;
  localparam int FB_EXCEPTION_LSB = 65;
  localparam int FB_BADV_LSB      = 72;
  localparam int FB_ENTRY_W       = 104;

  // Number of slots in a valid pair; the illegal 2'b10 counts as empty.
  function automatic logic [1:0] slot_count(input logic [1:0] v);
    case (v)
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [FB_ENTRY_W-1:0] pack_entry(
    input logic [31:0]       inst,
    input logic [31:0]       pc,
    input logic              excp_flag,
    input logic [EXCP_W-1:0] exception,
    input logic [31:0]       badv
  );
    return {badv, exception, excp_flag, pc, inst};
  endfunction

endpackage

// File: rtl/inst_fetch_buffer_entry_ram.sv
// Entry storage for the fetch buffer: two write ports, two asynchronous read ports.
// Storage is deliberately not reset; the pointers decide what is live.
module inst_fetch_buffer_entry_ram
  import inst_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic                  clk_i,
  input  logic                  we0_i,
  input  logic [PTR_W-1:0]      waddr0_i,
  input  logic [FB_ENTRY_W-1:0] wdata0_i,
  input  logic                  we1_i,
  input  logic [PTR_W-1:0]      waddr1_i,
  input  logic [FB_ENTRY_W-1:0] wdata1_i,
  input  logic [PTR_W-1:0]      raddr0_i,
  input  logic [PTR_W-1:0]      raddr1_i,
  output logic [FB_ENTRY_W-1:0] rdata0_o,
  output logic [FB_ENTRY_W-1:0] rdata1_o
);

  logic [FB_ENTRY_W-1:0] mem_q [DEPTH];

  // Write both slots of an accepted pair; the two addresses are always distinct.
  always_ff @(posedge clk_i) begin
    if (we0_i) mem_q[waddr0_i] <= wdata0_i;
    if (we1_i) mem_q[waddr1_i] <= wdata1_i;
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Dual-issue instruction buffer between IF and ID with first-word fall-through
// presentation. Optional performance counters are built when FB_PERF_EN is defined.
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              flush,
  input  logic              if_readygo,
  output logic              fb_allowin,
  input  logic [1:0]        if_valid,
  input  logic [31:0]       if_inst0,
  input  logic [31:0]       if_inst1,
  input  logic [31:0]       if_pc0,
  input  logic [31:0]       if_pc1,
  input  logic [1:0]        if_excp_flag,
  input  logic [EXCP_W-1:0] if_exception,
  input  logic [31:0]       if_badv,
  output logic              fifo_readygo,
  input  logic              id_allowin,
  output logic [1:0]        fifo_id_valid,
  output logic [31:0]       fifo_id_inst0,
  output logic [31:0]       fifo_id_inst1,
  output logic [31:0]       fifo_id_pc0,
  output logic [31:0]       fifo_id_pc1,
  output logic [31:0]       fifo_id_pc_next,
  output logic [1:0]        fifo_id_excp_flag,
  output logic [EXCP_W-1:0] fifo_id_exception,
  output logic [31:0]       fifo_id_badv,
  output logic [31:0]       perf_full_cyc,
  output logic [31:0]       perf_empty_cyc
);

  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d, free_slots;
  logic [PTR_W-1:0]      wr_ptr_p1, rd_ptr_p1;
  logic [1:0]            push_n, pop_n;
  logic [FB_ENTRY_W-1:0] head0, head1;
  logic                  v0, v1, flag0, flag1;

  // Space check uses the registered count only, so a full buffer stalls IF
  // even in a cycle where ID is draining it.
  assign free_slots = CNT_W'(DEPTH) - count_q;
  assign fb_allowin = (free_slots >= CNT_W'(2)) & ~flush;
  assign push_n     = (if_readygo & fb_allowin) ? slot_count(if_valid) : 2'd0;
  assign wr_ptr_p1  = wr_ptr_q + PTR_W'(1);
  assign rd_ptr_p1  = rd_ptr_q + PTR_W'(1);

  inst_fetch_buffer_entry_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_entry_ram (
    .clk_i    (aclk),
    .we0_i    (push_n != 2'd0),
    .waddr0_i (wr_ptr_q),
    .wdata0_i (pack_entry(if_inst0, if_pc0, if_excp_flag[0], if_exception, if_badv)),
    .we1_i    (push_n == 2'd2),
    .waddr1_i (wr_ptr_p1),
    .wdata1_i (pack_entry(if_inst1, if_pc1, if_excp_flag[1], if_exception, if_badv)),
    .raddr0_i (rd_ptr_q),
    .raddr1_i (rd_ptr_p1),
    .rdata0_o (head0),
    .rdata1_o (head1)
  );

  assign flag0 = head0[FB_EXCP_FLAG_LSB];
  assign flag1 = head1[FB_EXCP_FLAG_LSB];

  // An excepting head instruction is issued alone so ID never pairs it.
  assign v0 = (count_q != '0) & ~flush;
  assign v1 = (count_q >= CNT_W'(2)) & ~flush & ~flag0;

  assign fifo_readygo      = v0;
  assign fifo_id_valid     = {v1, v0};
  assign pop_n             = (v0 & id_allowin) ? slot_count({v1, v0}) : 2'd0;
  assign fifo_id_inst0     = v0 ? head0[FB_INST_LSB +: 32] : '0;
  assign fifo_id_inst1     = v1 ? head1[FB_INST_LSB +: 32] : '0;
  assign fifo_id_pc0       = v0 ? head0[FB_PC_LSB +: 32] : '0;
  assign fifo_id_pc1       = v1 ? head1[FB_PC_LSB +: 32] : '0;
  assign fifo_id_excp_flag = {v1 & flag1, v0 & flag0};

  // Report the exception of the oldest presented excepting slot, and the fall-through PC.
  always_comb begin
    fifo_id_exception = '0;
    fifo_id_badv      = '0;
    fifo_id_pc_next   = '0;
    if (v0 & flag0) begin
      fifo_id_exception = head0[FB_EXCEPTION_LSB +: EXCP_W];
      fifo_id_badv      = head0[FB_BADV_LSB +: 32];
    end else if (v1 & flag1) begin
      fifo_id_exception = head1[FB_EXCEPTION_LSB +: EXCP_W];
      fifo_id_badv      = head1[FB_BADV_LSB +: 32];
    end
    if (v1)      fifo_id_pc_next = head1[FB_PC_LSB +: 32] + 32'd4;
    else if (v0) fifo_id_pc_next = head0[FB_PC_LSB +: 32] + 32'd4;
  end

  // Next pointers/count; flush overrides any push or pop in the same cycle.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
    count_d  = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef FB_PERF_EN
  logic [31:0] perf_full_q, perf_empty_q;

  // Saturating stall/starve counters; only reset clears them, flush does not.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      perf_full_q  <= '0;
      perf_empty_q <= '0;
    end else begin
      if (if_readygo & ~fb_allowin & (perf_full_q != '1))
        perf_full_q <= perf_full_q + 32'd1;
      if ((count_q == '0) & id_allowin & (perf_empty_q != '1))
        perf_empty_q <= perf_empty_q + 32'd1;
    end
  end

  assign perf_full_cyc  = perf_full_q;
  assign perf_empty_cyc = perf_empty_q;
`else
  assign perf_full_cyc  = '0;
  assign perf_empty_cyc = '0;
`endif

  a_no_slot1_only: assert property (@(posedge aclk) disable iff (areset)
    if_readygo |-> (if_valid != 2'b10));

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer with hand-computed expectations.
module tb_inst_fetch_buffer;

`ifdef FB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        aclk, areset, flush, if_readygo, fb_allowin;
  logic [1:0]  if_valid, if_excp_flag;
  logic [31:0] if_inst0, if_inst1, if_pc0, if_pc1, if_badv;
  logic [6:0]  if_exception;
  logic        fifo_readygo, id_allowin;
  logic [1:0]  fifo_id_valid, fifo_id_excp_flag;
  logic [31:0] fifo_id_inst0, fifo_id_inst1, fifo_id_pc0, fifo_id_pc1, fifo_id_pc_next;
  logic [6:0]  fifo_id_exception;
  logic [31:0] fifo_id_badv, perf_full_cyc, perf_empty_cyc;

  int n_tests = 0;
  int n_fail  = 0;

  inst_fetch_buffer #(.DEPTH(8)) dut (
    .aclk(aclk), .areset(areset), .flush(flush),
    .if_readygo(if_readygo), .fb_allowin(fb_allowin), .if_valid(if_valid),
    .if_inst0(if_inst0), .if_inst1(if_inst1), .if_pc0(if_pc0), .if_pc1(if_pc1),
    .if_excp_flag(if_excp_flag), .if_exception(if_exception), .if_badv(if_badv),
    .fifo_readygo(fifo_readygo), .id_allowin(id_allowin), .fifo_id_valid(fifo_id_valid),
    .fifo_id_inst0(fifo_id_inst0), .fifo_id_inst1(fifo_id_inst1),
    .fifo_id_pc0(fifo_id_pc0), .fifo_id_pc1(fifo_id_pc1), .fifo_id_pc_next(fifo_id_pc_next),
    .fifo_id_excp_flag(fifo_id_excp_flag), .fifo_id_exception(fifo_id_exception),
    .fifo_id_badv(fifo_id_badv), .perf_full_cyc(perf_full_cyc), .perf_empty_cyc(perf_empty_cyc)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 0; if_readygo = 0; if_valid = 0; if_excp_flag = 0;
    if_exception = 0; if_badv = 0; id_allowin = 0;
  endtask

  // Advance to just after the next rising edge and drop all strobes.
  task automatic tick();
    @(posedge aclk);
    #1;
    idle_inputs();
  endtask

  task automatic push2(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pc);
    if_readygo = 1; if_valid = 2'b11;
    if_inst0 = i0; if_inst1 = i1; if_pc0 = pc; if_pc1 = pc + 32'd4;
  endtask

  initial begin
    areset = 1'b1;
    if_inst0 = 0; if_inst1 = 0; if_pc0 = 0; if_pc1 = 0;
    idle_inputs();
    #3;
    chk("rst_readygo", fifo_readygo, 0);
    chk("rst_valid", fifo_id_valid, 0);
    chk("rst_pc_next", fifo_id_pc_next, 0);
    chk("rst_inst0", fifo_id_inst0, 0);
    chk("rst_perf_full", perf_full_cyc, 0);
    chk("rst_perf_empty", perf_empty_cyc, 0);
    @(posedge aclk);
    #2 areset = 1'b0;
    tick();
    #2 chk("rst_allowin", fb_allowin, 1);

    // 1: single pair, FWFT with one cycle of latency, then popped
    push2(32'hA0, 32'hA1, 32'h1c00_0000);
    id_allowin = 1;
    #2 chk("t1_no_bypass", fifo_readygo, 0);
    chk("t1_allowin", fb_allowin, 1);
    tick();
    id_allowin = 1;
    #2 chk("t1_valid", fifo_id_valid, 2'b11);
    chk("t1_pc0", fifo_id_pc0, 32'h1c00_0000);
    chk("t1_pc_next", fifo_id_pc_next, 32'h1c00_0008);
    chk("t1_inst1", fifo_id_inst1, 32'hA1);
    tick();
    #2 chk("t1_empty_readygo", fifo_readygo, 0);
    chk("t1_empty_valid", fifo_id_valid, 0);

    // 2: fill with 4 pairs, then 3 stalled IF cycles
    for (int k = 0; k < 4; k++) begin
      push2(2*k, 2*k+1, 32'h2000 + 8*k);
      #2 chk("t2_allowin_fill", fb_allowin, 1);
      tick();
    end
    #2 chk("t2_full_valid", fifo_id_valid, 2'b11);
    chk("t2_full_inst0", fifo_id_inst0, 0);
    for (int k = 0; k < 3; k++) begin
      if_readygo = 1; if_valid = 2'b11;
      #2 chk("t2_allowin_full", fb_allowin, 0);
      tick();
    end
    #2 chk("t2_perf_full", perf_full_cyc, PERF ? 3 : 0);

    // 3: pop/push in the same cycle across the pointer wrap, then drain in order
    id_allowin = 1;
    #2 chk("t3a_inst0", fifo_id_inst0, 0);
    chk("t3a_inst1", fifo_id_inst1, 1);
    tick();
    push2(8, 9, 32'h3000);
    id_allowin = 1;
    #2 chk("t3b_inst0", fifo_id_inst0, 2);
    chk("t3b_inst1", fifo_id_inst1, 3);
    chk("t3b_allowin", fb_allowin, 1);
    tick();
    push2(10, 11, 32'h3008);
    id_allowin = 1;
    #2 chk("t3c_inst0", fifo_id_inst0, 4);
    chk("t3c_allowin", fb_allowin, 1);
    tick();
    if_readygo = 1; if_valid = 2'b01; if_inst0 = 12; if_pc0 = 32'h3010;
    #2 chk("t3d_allowin", fb_allowin, 1);
    tick();
    #2 chk("t3_allowin_cnt7", fb_allowin, 0);
    for (int i = 0; i < 3; i++) begin
      id_allowin = 1;
      #1 chk("t3_drain_valid", fifo_id_valid, 2'b11);
      chk("t3_drain_inst0", fifo_id_inst0, 6 + 2*i);
      chk("t3_drain_inst1", fifo_id_inst1, 7 + 2*i);
      tick();
    end
    id_allowin = 1;
    #2 chk("t3_last_valid", fifo_id_valid, 2'b01);
    chk("t3_last_inst0", fifo_id_inst0, 12);
    tick();
    #2 chk("t3_drained", fifo_readygo, 0);

    // 4: excepting slot0 is issued alone, slot1 follows
    push2(32'h100, 32'h101, 32'h1c00_0010);
    if_excp_flag = 2'b01; if_exception = 7'h08; if_badv = 32'h1c00_0010;
    tick();
    #2 chk("t4_valid", fifo_id_valid, 2'b01);
    chk("t4_exception", fifo_id_exception, 7'h08);
    chk("t4_badv", fifo_id_badv, 32'h1c00_0010);
    chk("t4_excp_flag", fifo_id_excp_flag, 2'b01);
    chk("t4_pc_next", fifo_id_pc_next, 32'h1c00_0014);
    id_allowin = 1;
    tick();
    #2 chk("t4_next_valid", fifo_id_valid, 2'b01);
    chk("t4_next_inst0", fifo_id_inst0, 32'h101);
    chk("t4_next_exception", fifo_id_exception, 0);
    chk("t4_next_badv", fifo_id_badv, 0);
    chk("t4_next_pc_next", fifo_id_pc_next, 32'h1c00_0018);
    id_allowin = 1;
    tick();
    #2 chk("t4_empty", fifo_readygo, 0);

    // 5: flush with 5 entries while IF is pushing
    push2(32'h200, 32'h201, 32'h4000);
    tick();
    push2(32'h202, 32'h203, 32'h4008);
    tick();
    if_readygo = 1; if_valid = 2'b01; if_inst0 = 32'h204;
    tick();
    #2 chk("t5_pre_inst0", fifo_id_inst0, 32'h200);
    flush = 1; if_readygo = 1; if_valid = 2'b11;
    #2 chk("t5_flush_readygo", fifo_readygo, 0);
    chk("t5_flush_allowin", fb_allowin, 0);
    chk("t5_flush_valid", fifo_id_valid, 0);
    tick();
    #2 chk("t5_post_readygo", fifo_readygo, 0);
    chk("t5_post_allowin", fb_allowin, 1);
    push2(32'h300, 32'h301, 32'h5000);
    tick();
    #2 chk("t5_refill_inst0", fifo_id_inst0, 32'h300);
    chk("t5_refill_inst1", fifo_id_inst1, 32'h301);
    id_allowin = 1;
    tick();
    #2 chk("t5_perf_full", perf_full_cyc, PERF ? 4 : 0);
    chk("t5_perf_empty", perf_empty_cyc, PERF ? 1 : 0);

    // 6: asynchronous reset between edges
    push2(32'h400, 32'h401, 32'h6000);
    tick();
    #2 chk("t6_pre_valid", fifo_id_valid, 2'b11);
    #1 areset = 1'b1;
    #1 chk("t6_rst_valid", fifo_id_valid, 0);
    chk("t6_rst_readygo", fifo_readygo, 0);
    chk("t6_rst_perf_full", perf_full_cyc, 0);
    #2 areset = 1'b0;
    tick();
    push2(32'h500, 32'h501, 32'h7000);
    #2 chk("t6_no_bypass", fifo_readygo, 0);
    tick();
    #2 chk("t6_post_valid", fifo_id_valid, 2'b11);
    chk("t6_post_inst0", fifo_id_inst0, 32'h500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
